// File: rtl/video_timing_gen.sv
// Video raster timing generator.
// Walks a pixel position (h_cnt, v_cnt) over an H_TOTAL x V_TOTAL raster,
// advancing one pixel per clock with ce=1, and produces sync, blanking and
// coordinate outputs that all describe the current position with no skew.
//
// Ports:
//   clock          single clock
//   rst            synchronous active-low reset
//   ce             pixel clock enable
//   horiz_sync     horizontal sync, asserted level = SYNC_POL
//   vert_sync      vertical sync, asserted level = SYNC_POL
//   video_on       high inside the active area
//   pixel_column   raw horizontal count (h_cnt)
//   pixel_row      raw vertical count (v_cnt)
//   scaled_column  pixel_column >> SCALE_SHIFT
//   scaled_row     pixel_row >> SCALE_SHIFT
//   line_start     one-clock pulse when the position moves to column 0
//   frame_start    one-clock pulse when the position moves to (0,0)
//   frame_count    number of frame starts, modulo 2^FRAME_W
module video_timing_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SYNC_POL    = 0,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned CW          = 10,
    parameter int unsigned FRAME_W     = 8
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               ce,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               video_on,
    output logic [CW-1:0]      pixel_column,
    output logic [CW-1:0]      pixel_row,
    output logic [CW-1:0]      scaled_column,
    output logic [CW-1:0]      scaled_row,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic        SYNC_ON  = (SYNC_POL != 0);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          von_nxt;
    logic          hs_act_nxt;
    logic          vs_act_nxt;

    // Next raster position; outputs are decoded from it so that every
    // registered output lines up with the counters in the same cycle.
    always_comb begin
        h_nxt  = h_cnt + CW'(1);
        v_nxt  = v_cnt;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (h_cnt == H_LAST) begin
            h_nxt  = '0;
            h_wrap = 1'b1;
            if (v_cnt == V_LAST) begin
                v_nxt  = '0;
                v_wrap = 1'b1;
            end else begin
                v_nxt = v_cnt + CW'(1);
            end
        end
    end

    // Decode of the next position.
    always_comb begin
        von_nxt    = (h_nxt < CW'(H_ACTIVE)) && (v_nxt < CW'(V_ACTIVE));
        hs_act_nxt = (h_nxt >= CW'(HS_START)) && (h_nxt < CW'(HS_END));
        vs_act_nxt = (v_nxt >= CW'(VS_START)) && (v_nxt < CW'(VS_END));
    end

    // Position, level outputs and pulses; everything holds while ce=0
    // except the pulses, which only live for the cycle after an enable.
    always_ff @(posedge clock) begin
        if (!rst) begin
            h_cnt         <= H_LAST;
            v_cnt         <= V_LAST;
            scaled_column <= H_LAST >> SCALE_SHIFT;
            scaled_row    <= V_LAST >> SCALE_SHIFT;
            video_on      <= 1'b0;
            horiz_sync    <= ~SYNC_ON;
            vert_sync     <= ~SYNC_ON;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            frame_count   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                h_cnt         <= h_nxt;
                v_cnt         <= v_nxt;
                scaled_column <= h_nxt >> SCALE_SHIFT;
                scaled_row    <= v_nxt >> SCALE_SHIFT;
                video_on      <= von_nxt;
                horiz_sync    <= hs_act_nxt ? SYNC_ON : ~SYNC_ON;
                vert_sync     <= vs_act_nxt ? SYNC_ON : ~SYNC_ON;
                line_start    <= h_wrap;
                frame_start   <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + FRAME_W'(1);
                end
            end
        end
    end

    assign pixel_column = h_cnt;
    assign pixel_row    = v_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four instances with different geometry and
// sync polarity share clock/rst/ce. A behavioural raster model predicts
// every output of every instance each cycle (queued when stimulus is
// driven, popped after the edge), alongside a constant vector table and
// hand-written corner sequences.
module tb_video_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, sh, fw;
    } cfg_t;

    typedef struct {
        int   col, row, scol, srow, fc;
        logic hs, vs, von, ls, fs;
    } exp_t;

    typedef struct {
        logic r, c;
        int   col, row;
        logic von, ls, fs, hs;
        int   fc;
    } vec_t;

    logic clock, rst, ce;
    logic       hs_w[4], vs_w[4], von_w[4], ls_w[4], fs_w[4];
    logic [9:0] col_w[4], row_w[4], scol_w[4], srow_w[4];
    logic [7:0] fc_w[4];

    int   n_err = 0;
    int   n_checks = 0;
    int   cyc = 0;
    cfg_t cfg[4];
    int   mh[4], mv[4], mfc[4];
    exp_t sb[$];
    vec_t vt[12];

    // dut0: default geometry, active-low sync
    video_timing_gen u_dut0 (
        .clock(clock), .rst(rst), .ce(ce),
        .horiz_sync(hs_w[0]), .vert_sync(vs_w[0]), .video_on(von_w[0]),
        .pixel_column(col_w[0]), .pixel_row(row_w[0]),
        .scaled_column(scol_w[0]), .scaled_row(srow_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]), .frame_count(fc_w[0])
    );

    // dut1: tiny 16x8 raster, active-high sync, used for frame counter wrap
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
    ) u_dut1 (
        .clock(clock), .rst(rst), .ce(ce),
        .horiz_sync(hs_w[1]), .vert_sync(vs_w[1]), .video_on(von_w[1]),
        .pixel_column(col_w[1]), .pixel_row(row_w[1]),
        .scaled_column(scol_w[1]), .scaled_row(srow_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]), .frame_count(fc_w[1])
    );

    // dut2: short lines, default vertical geometry, for row-side checks
    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2)
    ) u_dut2 (
        .clock(clock), .rst(rst), .ce(ce),
        .horiz_sync(hs_w[2]), .vert_sync(vs_w[2]), .video_on(von_w[2]),
        .pixel_column(col_w[2]), .pixel_row(row_w[2]),
        .scaled_column(scol_w[2]), .scaled_row(srow_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]), .frame_count(fc_w[2])
    );

    // dut3: default geometry, active-high sync
    video_timing_gen #(
        .SYNC_POL(1)
    ) u_dut3 (
        .clock(clock), .rst(rst), .ce(ce),
        .horiz_sync(hs_w[3]), .vert_sync(vs_w[3]), .video_on(von_w[3]),
        .pixel_column(col_w[3]), .pixel_row(row_w[3]),
        .scaled_column(scol_w[3]), .scaled_row(srow_w[3]),
        .line_start(ls_w[3]), .frame_start(fs_w[3]), .frame_count(fc_w[3])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t predict(cfg_t c, int h, int v, int fc, logic ls, logic fs);
        exp_t e;
        logic pol;
        logic hact, vact;
        pol    = (c.pol != 0);
        hact   = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
        vact   = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
        e.col  = h;
        e.row  = v;
        e.scol = h >> c.sh;
        e.srow = v >> c.sh;
        e.fc   = fc;
        e.von  = (h < c.ha) && (v < c.va);
        e.hs   = hact ? pol : ~pol;
        e.vs   = vact ? pol : ~pol;
        e.ls   = ls;
        e.fs   = fs;
        return e;
    endfunction

    function automatic exp_t get_act(int i);
        exp_t a;
        a.col  = int'(col_w[i]);
        a.row  = int'(row_w[i]);
        a.scol = int'(scol_w[i]);
        a.srow = int'(srow_w[i]);
        a.fc   = int'(fc_w[i]);
        a.hs   = hs_w[i];
        a.vs   = vs_w[i];
        a.von  = von_w[i];
        a.ls   = ls_w[i];
        a.fs   = fs_w[i];
        return a;
    endfunction

    // Advance the raster model for one edge and queue the predictions.
    task automatic model_step(input logic r, input logic c);
        for (int i = 0; i < 4; i++) begin
            int   ht, vt_n;
            logic ls, fs;
            ht   = cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
            vt_n = cfg[i].va + cfg[i].vfp + cfg[i].vs + cfg[i].vbp;
            ls = 1'b0;
            fs = 1'b0;
            if (!r) begin
                mh[i]  = ht - 1;
                mv[i]  = vt_n - 1;
                mfc[i] = 0;
            end else if (c) begin
                if (mh[i] == ht - 1) begin
                    mh[i] = 0;
                    ls = 1'b1;
                    if (mv[i] == vt_n - 1) begin
                        mv[i] = 0;
                        fs = 1'b1;
                    end else begin
                        mv[i] = mv[i] + 1;
                    end
                end else begin
                    mh[i] = mh[i] + 1;
                end
                if (fs) mfc[i] = (mfc[i] + 1) % (1 << cfg[i].fw);
            end
            sb.push_back(predict(cfg[i], mh[i], mv[i], mfc[i], ls, fs));
        end
    endtask

    // Drive one clock of stimulus, then compare all instances after the edge.
    task automatic cycle(input logic r, input logic c);
        rst = r;
        ce  = c;
        model_step(r, c);
        @(posedge clock);
        @(negedge clock);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            exp_t e, a;
            e = sb.pop_front();
            a = get_act(i);
            n_checks++;
            if (a.col != e.col || a.row != e.row || a.scol != e.scol ||
                a.srow != e.srow || a.fc != e.fc || a.hs !== e.hs ||
                a.vs !== e.vs || a.von !== e.von || a.ls !== e.ls ||
                a.fs !== e.fs) begin
                n_err++;
                $display("FAIL sb dut%0d cyc=%0d got col=%0d row=%0d sc=%0d sr=%0d fc=%0d hs=%b vs=%b von=%b ls=%b fs=%b exp col=%0d row=%0d sc=%0d sr=%0d fc=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                         i, cyc, a.col, a.row, a.scol, a.srow, a.fc, a.hs, a.vs, a.von, a.ls, a.fs,
                         e.col, e.row, e.scol, e.srow, e.fc, e.hs, e.vs, e.von, e.ls, e.fs);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    // Run with ce=1 until the model of instance i sits at (h,v); v<0 matches any row.
    task automatic run_until(input int i, input int h, input int v, input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 50000; k++) begin
            if (mh[i] == h && (v < 0 || mv[i] == v)) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1, 1'b1);
        end
        n_checks++;
        if (!found) begin
            n_err++;
            $display("FAIL timeout %s got=not_reached exp=reached", name);
        end
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2, 8};
        cfg[1] = '{8, 2, 3, 3, 4, 1, 2, 1, 1, 2, 8};
        cfg[2] = '{4, 1, 1, 2, 480, 10, 2, 33, 0, 2, 8};
        cfg[3] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 2, 8};
        for (int i = 0; i < 4; i++) begin
            mh[i] = 0; mv[i] = 0; mfc[i] = 0;
        end

        // dut0 expectations: r, c, col, row, von, ls, fs, hs, fc
        vt[0]  = '{1'b0, 1'b0, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vt[1]  = '{1'b0, 1'b1, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vt[2]  = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vt[3]  = '{1'b1, 1'b1, 0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1};
        vt[4]  = '{1'b1, 1'b0, 0,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[5]  = '{1'b1, 1'b0, 0,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[6]  = '{1'b1, 1'b0, 0,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[7]  = '{1'b1, 1'b1, 1,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[8]  = '{1'b1, 1'b0, 1,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[9]  = '{1'b1, 1'b0, 1,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[10] = '{1'b1, 1'b0, 1,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[11] = '{1'b1, 1'b1, 2,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1};

        rst = 1'b0;
        ce  = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].r, vt[i].c);
            n_checks++;
            if (int'(col_w[0]) != vt[i].col || int'(row_w[0]) != vt[i].row ||
                von_w[0] !== vt[i].von || ls_w[0] !== vt[i].ls ||
                fs_w[0] !== vt[i].fs || hs_w[0] !== vt[i].hs ||
                int'(fc_w[0]) != vt[i].fc) begin
                n_err++;
                $display("FAIL vec%0d got col=%0d row=%0d von=%b ls=%b fs=%b hs=%b fc=%0d exp col=%0d row=%0d von=%b ls=%b fs=%b hs=%b fc=%0d",
                         i, col_w[0], row_w[0], von_w[0], ls_w[0], fs_w[0], hs_w[0], fc_w[0],
                         vt[i].col, vt[i].row, vt[i].von, vt[i].ls, vt[i].fs, vt[i].hs, vt[i].fc);
            end
        end
        chk("dut1_reset_pol_hs_after_vec", int'(hs_w[1]), 0);

        // Horizontal boundaries on the default raster.
        run_until(0, 639, 0, "col639");
        chk("col639_scaled", int'(scol_w[0]), 159);
        chk("col639_von", int'(von_w[0]), 1);
        run_until(0, 640, 0, "col640");
        chk("col640_von", int'(von_w[0]), 0);
        run_until(0, 655, 0, "col655");
        chk("col655_hs", int'(hs_w[0]), 1);
        chk("col655_hs_pol1", int'(hs_w[3]), 0);
        run_until(0, 656, 0, "col656");
        chk("col656_hs", int'(hs_w[0]), 0);
        chk("col656_hs_pol1", int'(hs_w[3]), 1);
        run_until(0, 751, 0, "col751");
        chk("col751_hs", int'(hs_w[0]), 0);
        chk("col751_hs_pol1", int'(hs_w[3]), 1);
        run_until(0, 752, 0, "col752");
        chk("col752_hs", int'(hs_w[0]), 1);
        chk("col752_hs_pol1", int'(hs_w[3]), 0);
        run_until(0, 0, 1, "row1_start");
        chk("row1_line_start", int'(ls_w[0]), 1);
        chk("row1_frame_start", int'(fs_w[0]), 0);
        chk("row1_row", int'(row_w[0]), 1);

        // Vertical boundaries on the short-line instance.
        run_until(2, 3, 479, "row479");
        chk("row479_scaled", int'(srow_w[2]), 119);
        chk("row479_von", int'(von_w[2]), 1);
        run_until(2, 4, 479, "row479_col4");
        chk("row479_col4_von", int'(von_w[2]), 0);
        run_until(2, 0, 489, "row489");
        chk("row489_vs", int'(vs_w[2]), 1);
        run_until(2, 0, 490, "row490");
        chk("row490_vs", int'(vs_w[2]), 0);
        run_until(2, 7, 491, "row491_end");
        chk("row491_end_vs", int'(vs_w[2]), 0);
        run_until(2, 0, 492, "row492");
        chk("row492_vs", int'(vs_w[2]), 1);

        // Frame counter wrap 255 -> 0 on the tiny raster.
        begin
            logic wrapped;
            int   last_fc;
            wrapped = 1'b0;
            last_fc = mfc[1];
            for (int k = 0; k < 40000; k++) begin
                cycle(1'b1, 1'b1);
                if (last_fc == 255 && mfc[1] == 0) begin
                    wrapped = 1'b1;
                    break;
                end
                last_fc = mfc[1];
            end
            chk("fc_wrap_reached", int'(wrapped), 1);
            chk("fc_wrap_value", int'(fc_w[1]), 0);
            chk("fc_wrap_fs", int'(fs_w[1]), 1);
        end

        // Mid-frame reset at column 300, then restart.
        run_until(0, 300, -1, "col300");
        chk("col300_col", int'(col_w[0]), 300);
        cycle(1'b0, 1'b1);
        chk("rst_col", int'(col_w[0]), 799);
        chk("rst_row", int'(row_w[0]), 524);
        chk("rst_scol", int'(scol_w[0]), 199);
        chk("rst_srow", int'(srow_w[0]), 131);
        chk("rst_von", int'(von_w[0]), 0);
        chk("rst_hs", int'(hs_w[0]), 1);
        chk("rst_vs", int'(vs_w[0]), 1);
        chk("rst_ls", int'(ls_w[0]), 0);
        chk("rst_fs", int'(fs_w[0]), 0);
        chk("rst_fc", int'(fc_w[0]), 0);
        chk("rst_hs_pol1", int'(hs_w[3]), 0);
        cycle(1'b1, 1'b1);
        chk("restart_col", int'(col_w[0]), 0);
        chk("restart_row", int'(row_w[0]), 0);
        chk("restart_von", int'(von_w[0]), 1);
        chk("restart_fs", int'(fs_w[0]), 1);
        chk("restart_ls", int'(ls_w[0]), 1);
        chk("restart_fc", int'(fc_w[0]), 1);
        cycle(1'b1, 1'b0);
        chk("restart_hold_fs", int'(fs_w[0]), 0);
        chk("restart_hold_col", int'(col_w[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
